// File: rtl/wb_cmd_regs.sv
// Wishbone register front-end that issues byte-engine commands and collects their responses; FSMR readback enabled by WB_CMD_REGS_FSMR_EN.
// ack_o and dat_o arrive one cycle after strobe; commands are held in ISSUE until cmd_ready_i accepts them.
module wb_cmd_regs #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] adr_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic                  ack_o,
    output logic                  irq_o,
    output logic                  cmd_valid_o,
    input  logic                  cmd_ready_i,
    output logic [2:0]            cmd_code_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    input  logic                  rsp_valid_i,
    input  logic [1:0]            rsp_code_i,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    input  logic                  bus_busy_i,
    input  logic                  bus_cap_i,
    input  logic [DATA_WIDTH-1:0] fsm_state_i
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic                  bus_ready;
    logic                  csr_e;
    logic                  csr_ie;
    logic [3:0]            bus_id;
    logic                  bb_q;
    logic                  bc_q;
    logic [DATA_WIDTH-1:0] tx_byte;
    logic [DATA_WIDTH-1:0] rx_byte;
    logic [3:0]            flags;      // {DON, NAK, AL, ERR}
    logic [3:0]            flags_nxt;
    logic                  irq_pending;
    logic [DATA_WIDTH-1:0] fsmr_word;
    logic [DATA_WIDTH-1:0] rd_word;

    logic bus_req;
    logic sel_csr, sel_dpr, sel_cmdr, sel_fsmr;
    logic wr_csr, wr_dpr, wr_cmdr, rd_cmdr;
    logic e_clear;
    logic cmd_accept, cmd_reject, rsp_accept;

    // bus_ready holds off the first ack until the second edge after reset release
    assign bus_req  = cyc_i & stb_i & ~ack_o & bus_ready;
    assign sel_csr  = (adr_i == ADDR_WIDTH'(0));
    assign sel_dpr  = (adr_i == ADDR_WIDTH'(1));
    assign sel_cmdr = (adr_i == ADDR_WIDTH'(2));
    assign sel_fsmr = (adr_i == ADDR_WIDTH'(3));

    assign wr_csr  = bus_req & we_i & sel_csr;
    assign wr_dpr  = bus_req & we_i & sel_dpr;
    assign wr_cmdr = bus_req & we_i & sel_cmdr;
    assign rd_cmdr = bus_req & ~we_i & sel_cmdr;

    assign e_clear    = wr_csr & ~dat_i[DATA_WIDTH-1];
    assign cmd_accept = wr_cmdr & csr_e & (state == ST_IDLE);
    assign cmd_reject = wr_cmdr & csr_e & (state != ST_IDLE);
    assign rsp_accept = rsp_valid_i & (state == ST_WAIT) & ~e_clear;

`ifdef WB_CMD_REGS_FSMR_EN
    logic [DATA_WIDTH-1:0] fsm_state_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fsm_state_q <= '0;
        end else begin
            fsm_state_q <= fsm_state_i;
        end
    end

    assign fsmr_word = fsm_state_q;
`else
    logic unused_fsm_state;

    assign unused_fsm_state = ^fsm_state_i;
    assign fsmr_word        = '0;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (e_clear) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (cmd_accept)  state_nxt = ST_ISSUE;
                ST_ISSUE: if (cmd_ready_i) state_nxt = ST_WAIT;
                ST_WAIT:  if (rsp_accept)  state_nxt = ST_IDLE;
                default:                   state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cmd_valid_o = (state == ST_ISSUE);
    end

    // Response code n maps onto flag bit 3-n, so DON lands in the MSB
    always_comb begin
        flags_nxt = flags;
        if (cmd_accept) begin
            flags_nxt = 4'b0000;
        end else begin
            if (rsp_accept) begin
                flags_nxt = flags_nxt | (4'b1000 >> rsp_code_i);
            end
            if (cmd_reject) begin
                flags_nxt[0] = 1'b1;
            end
        end
    end

    // Register layout assumes DATA_WIDTH >= 8: flags in the top nibble, fields at the bottom
    always_comb begin
        rd_word = '0;
        if (sel_csr) begin
            rd_word[DATA_WIDTH-1] = csr_e;
            rd_word[DATA_WIDTH-2] = csr_ie;
            rd_word[DATA_WIDTH-3] = bb_q;
            rd_word[DATA_WIDTH-4] = bc_q;
            rd_word[3:0]          = bus_id;
        end else if (sel_dpr) begin
            rd_word = rx_byte;
        end else if (sel_cmdr) begin
            rd_word[DATA_WIDTH-1:DATA_WIDTH-4] = flags;
            rd_word[2:0]                       = cmd_code_o;
        end else if (sel_fsmr) begin
            rd_word = fsmr_word;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bus_ready <= 1'b0;
            ack_o     <= 1'b0;
            dat_o     <= '0;
        end else begin
            bus_ready <= 1'b1;
            ack_o     <= bus_req;
            dat_o     <= (bus_req & ~we_i) ? rd_word : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            csr_e   <= 1'b0;
            csr_ie  <= 1'b0;
            bus_id  <= '0;
            bb_q    <= 1'b0;
            bc_q    <= 1'b0;
            tx_byte <= '0;
        end else begin
            bb_q <= bus_busy_i;
            bc_q <= bus_cap_i;
            if (wr_csr) begin
                csr_e  <= dat_i[DATA_WIDTH-1];
                csr_ie <= dat_i[DATA_WIDTH-2];
                bus_id <= dat_i[3:0];
            end
            if (wr_dpr) begin
                tx_byte <= dat_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cmd_code_o  <= '0;
            wr_data_o   <= '0;
            rx_byte     <= '0;
            flags       <= '0;
            irq_pending <= 1'b0;
            irq_o       <= 1'b0;
        end else begin
            if (cmd_accept) begin
                cmd_code_o <= dat_i[2:0];
                wr_data_o  <= tx_byte;
            end
            if (rsp_accept) begin
                rx_byte <= rd_data_i;
            end
            flags <= flags_nxt;
            // a new event on the same edge as a CMDR read keeps the interrupt pending
            irq_pending <= (irq_pending & ~rd_cmdr) | rsp_accept | cmd_reject;
            irq_o       <= csr_ie & irq_pending;
        end
    end

endmodule

// File: tb/tb_wb_cmd_regs.sv
// Bench for wb_cmd_regs: directed Wishbone traffic, expected read data and commands queued, checked by monitors.
module tb_wb_cmd_regs;

    localparam int AW = 2;
    localparam int DW = 8;

`ifdef WB_CMD_REGS_FSMR_EN
    localparam logic [7:0] FSMR_EXP = 8'h5A;
`else
    localparam logic [7:0] FSMR_EXP = 8'h00;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          cyc_i = 1'b0;
    logic          stb_i = 1'b0;
    logic          we_i = 1'b0;
    logic [AW-1:0] adr_i = '0;
    logic [DW-1:0] dat_i = '0;
    logic [DW-1:0] dat_o;
    logic          ack_o;
    logic          irq_o;
    logic          cmd_valid_o;
    logic          cmd_ready_i = 1'b0;
    logic [2:0]    cmd_code_o;
    logic [DW-1:0] wr_data_o;
    logic          rsp_valid_i = 1'b0;
    logic [1:0]    rsp_code_i = '0;
    logic [DW-1:0] rd_data_i = '0;
    logic          bus_busy_i = 1'b0;
    logic          bus_cap_i = 1'b0;
    logic [DW-1:0] fsm_state_i = '0;

    wb_cmd_regs #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
        .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o), .irq_o(irq_o),
        .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i), .cmd_code_o(cmd_code_o),
        .wr_data_o(wr_data_o), .rsp_valid_i(rsp_valid_i), .rsp_code_i(rsp_code_i),
        .rd_data_i(rd_data_i), .bus_busy_i(bus_busy_i), .bus_cap_i(bus_cap_i),
        .fsm_state_i(fsm_state_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [2:0] code;
        logic [7:0] data;
    } cmd_t;

    logic [7:0] ack_q[$];
    cmd_t       cmd_q[$];

    int checks = 0;
    int passes = 0;
    int cmd_hs = 0;
    int cmd_vld_cycles = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Bus monitor: every ack pops one expected dat_o; dat_o must be 0 otherwise
    logic       prev_ack = 1'b0;
    logic       prev_vld = 1'b0;
    logic [2:0] held_code = '0;
    logic [7:0] held_data = '0;

    always @(negedge clk_i) begin
        if (ack_o) begin
            check("ack_not_consecutive", int'(prev_ack), 0);
            if (ack_q.size() == 0) begin
                check("unexpected_ack", int'(ack_o), 0);
            end else begin
                logic [7:0] e;
                e = ack_q.pop_front();
                check("dat_o", int'(dat_o), int'(e));
            end
        end else begin
            check("dat_o_idle", int'(dat_o), 0);
        end
        prev_ack = ack_o;

        if (cmd_valid_o) begin
            cmd_vld_cycles++;
            if (prev_vld) begin
                check("cmd_code_stable", int'(cmd_code_o), int'(held_code));
                check("wr_data_stable", int'(wr_data_o), int'(held_data));
            end
            held_code = cmd_code_o;
            held_data = wr_data_o;
            if (cmd_ready_i) begin
                cmd_hs++;
                if (cmd_q.size() == 0) begin
                    check("unexpected_cmd", int'(cmd_valid_o), 0);
                end else begin
                    cmd_t c;
                    c = cmd_q.pop_front();
                    check("cmd_code", int'(cmd_code_o), int'(c.code));
                    check("cmd_wr_data", int'(wr_data_o), int'(c.data));
                end
            end
        end
        prev_vld = cmd_valid_o;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // One Wishbone transfer, optionally with a response pulse on the ack edge
    task automatic wb(input logic we, input logic [1:0] adr, input logic [7:0] dat,
                      input logic [7:0] exp, input int lat,
                      input logic rsp, input logic [1:0] rcode, input logic [7:0] rdat);
        int n;
        n = 0;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; dat_i = dat;
        ack_q.push_back(we ? 8'h00 : exp);
        if (rsp) begin
            rsp_valid_i = 1'b1; rsp_code_i = rcode; rd_data_i = rdat;
        end
        do begin
            @(posedge clk_i);
            #1;
            n++;
            rsp_valid_i = 1'b0;
        end while (!ack_o && n < 8);
        check("ack_latency", n, lat);
        if (!ack_o) ack_q.delete();
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        idle(1);
    endtask

    task automatic wr(input logic [1:0] adr, input logic [7:0] dat);
        wb(1'b1, adr, dat, 8'h00, 1, 1'b0, 2'd0, 8'h00);
    endtask

    task automatic rd(input logic [1:0] adr, input logic [7:0] exp);
        wb(1'b0, adr, 8'h00, exp, 1, 1'b0, 2'd0, 8'h00);
    endtask

    task automatic rsp_pulse(input logic [1:0] code, input logic [7:0] data);
        rsp_valid_i = 1'b1; rsp_code_i = code; rd_data_i = data;
        @(posedge clk_i);
        #1;
        rsp_valid_i = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_ack", int'(ack_o), 0);
        check("rst_irq", int'(irq_o), 0);
        check("rst_cmd_valid", int'(cmd_valid_o), 0);
        check("rst_cmd_code", int'(cmd_code_o), 0);
        check("rst_wr_data", int'(wr_data_o), 0);
        #2 rst_i = 1'b1;
        idle(2);

        // CMDR write with E=0 is ignored
        wr(2'd2, 8'h04);
        check("e0_cmd_valid", int'(cmd_valid_o), 0);
        rd(2'd2, 8'h00);

        // CSR read/write, read-only BB/BC follow the status pins
        wr(2'd0, 8'hC0);
        rd(2'd0, 8'hC0);
        bus_busy_i = 1'b1;
        wr(2'd0, 8'hFA);
        rd(2'd0, 8'hEA);
        bus_busy_i = 1'b0; bus_cap_i = 1'b1;
        idle(2);
        rd(2'd0, 8'hDA);
        bus_cap_i = 1'b0;
        wr(2'd0, 8'hC0);

        // Full command / response round trip
        cmd_ready_i = 1'b1;
        wr(2'd1, 8'hA5);
        cmd_q.push_back('{code: 3'd1, data: 8'hA5});
        wr(2'd2, 8'h01);
        rsp_pulse(2'd0, 8'h3C);
        idle(2);
        check("irq_after_rsp", int'(irq_o), 1);
        check("cmd_valid_one_cycle", cmd_vld_cycles, 1);
        rd(2'd2, 8'h81);
        idle(1);
        check("irq_cleared", int'(irq_o), 0);
        rd(2'd1, 8'h3C);

        // CMDR write while WAIT is rejected with ERR
        wr(2'd1, 8'h11);
        cmd_q.push_back('{code: 3'd3, data: 8'h11});
        wr(2'd2, 8'h03);
        wr(2'd2, 8'h02);
        check("reject_code_held", int'(cmd_code_o), 3);
        check("reject_data_held", int'(wr_data_o), 8'h11);
        idle(1);
        check("irq_after_reject", int'(irq_o), 1);
        rd(2'd2, 8'h13);

        // Response and rejected write on the same edge set both AL and ERR
        wb(1'b1, 2'd2, 8'h05, 8'h00, 1, 1'b1, 2'd2, 8'h77);
        rd(2'd2, 8'h33);
        rd(2'd1, 8'h77);

        // CMDR read on the same edge as a response: pending stays set
        cmd_q.push_back('{code: 3'd4, data: 8'h11});
        wr(2'd2, 8'h04);
        wb(1'b0, 2'd2, 8'h00, 8'h04, 1, 1'b1, 2'd1, 8'h99);
        idle(1);
        check("irq_set_wins", int'(irq_o), 1);
        rd(2'd2, 8'h44);
        idle(1);
        check("irq_cleared_2", int'(irq_o), 0);

        // Clearing E while in ISSUE cancels the command and drops later responses
        cmd_ready_i = 1'b0;
        wr(2'd2, 8'h06);
        check("issue_cmd_valid", int'(cmd_valid_o), 1);
        wr(2'd0, 8'h40);
        check("e_clear_cmd_valid", int'(cmd_valid_o), 0);
        rsp_pulse(2'd0, 8'hEE);
        idle(2);
        check("discarded_rsp_irq", int'(irq_o), 0);
        rd(2'd2, 8'h06);
        rd(2'd1, 8'h99);
        cmd_ready_i = 1'b1;
        idle(2);
        check("cmd_handshakes", cmd_hs, 3);

        // FSMR readback, writes ignored
        fsm_state_i = 8'h5A;
        idle(2);
        rd(2'd3, FSMR_EXP);
        wr(2'd3, 8'hFF);
        rd(2'd3, FSMR_EXP);

        // Reset during ISSUE with a read in flight
        wr(2'd0, 8'hC0);
        cmd_ready_i = 1'b0;
        wr(2'd1, 8'h22);
        wr(2'd2, 8'h07);
        wr(2'd2, 8'h01);
        check("pre_rst_cmd_valid", int'(cmd_valid_o), 1);
        check("pre_rst_irq", int'(irq_o), 1);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 2'd0;
        #2 rst_i = 1'b0;
        #1;
        check("mid_rst_cmd_valid", int'(cmd_valid_o), 0);
        check("mid_rst_irq", int'(irq_o), 0);
        check("mid_rst_ack", int'(ack_o), 0);
        repeat (2) @(posedge clk_i);
        #1;
        cyc_i = 1'b0; stb_i = 1'b0;
        #2 rst_i = 1'b1;
        wb(1'b0, 2'd0, 8'h00, 8'h00, 2, 1'b0, 2'd0, 8'h00);
        rd(2'd2, 8'h00);
        check("post_rst_cmd_valid", int'(cmd_valid_o), 0);
        check("post_rst_wr_data", int'(wr_data_o), 0);
        idle(2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
